// File: rtl/secure_reg_bank_pkg.sv
// Shared types and defaults for the access-controlled register bank.
package secure_reg_bank_pkg;

  localparam int         RSP_DATA_W    = 8;
  localparam logic [2:0] ADMIN_ID_DFLT = 3'h4;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Response payload; rdata width tracks the bank's default data width.
  typedef struct packed {
    logic                  valid;
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/secure_reg_bank_access_checker.sv
// Combinational grant/deny decision for one request against the live owner table.
module access_checker #(
  parameter int               ID_W     = 3,
  parameter int               NUM_REGS = 4,
  parameter int               ADDR_W   = 2,
  parameter logic [ID_W-1:0]  ADMIN_ID = 3'h4
) (
  input  logic [ID_W-1:0]                req_id,
  input  logic                           req_cfg,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [NUM_REGS-1:0][ID_W-1:0]  owner_tbl,
  output logic                           grant
);

  logic            addr_hit_s;
  logic [ID_W-1:0] owner_s;
  logic            is_admin_s;

  // Select the addressed owner; indices beyond NUM_REGS never hit and are denied.
  always_comb begin
    addr_hit_s = 1'b0;
    owner_s    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      addr_hit_s = addr_hit_s | (req_addr == ADDR_W'(i));
      owner_s    = owner_s | (owner_tbl[i] & {ID_W{req_addr == ADDR_W'(i)}});
    end
    is_admin_s = (req_id == ADMIN_ID);
    grant      = addr_hit_s && (is_admin_s || (!req_cfg && (req_id == owner_s)));
  end

endmodule

// File: rtl/secure_reg_bank.sv
// Register bank with per-register owner IDs, same-cycle access checks and a
// timed lockout after repeated denials.
module secure_reg_bank
  import secure_reg_bank_pkg::*;
#(
  parameter int              DATA_W      = RSP_DATA_W,
  parameter int              ID_W        = 3,
  parameter int              NUM_REGS    = 4,
  parameter logic [ID_W-1:0] ADMIN_ID    = ID_W'(ADMIN_ID_DFLT),
  parameter int              MAX_FAIL    = 3,
  parameter int              LOCK_CYCLES = 16,
  localparam int             ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_cfg,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ID_W-1:0]   req_id,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              locked
);

  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int TMR_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [NUM_REGS-1:0][DATA_W-1:0] data_r;
  logic [NUM_REGS-1:0][ID_W-1:0]   owner_r;

  state_e             state_r, state_d;
  logic [FAIL_W-1:0]  fail_r, fail_d;
  logic [TMR_W-1:0]   timer_r, timer_d;
  rsp_t               rsp_r, rsp_d;

  logic               accept_s;
  logic               grant_s;
  logic               wr_en_s;
  logic [DATA_W-1:0]  rd_data_s;
  logic [ID_W-1:0]    rd_owner_s;

  access_checker #(
    .ID_W     (ID_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ADMIN_ID (ADMIN_ID)
  ) u_access_checker (
    .req_id    (req_id),
    .req_cfg   (req_cfg),
    .req_addr  (req_addr),
    .owner_tbl (owner_r),
    .grant     (grant_s)
  );

  assign locked    = (state_r == ST_LOCKED);
  assign req_ready = !locked;
  assign accept_s  = req_valid && req_ready;
  assign wr_en_s   = accept_s && grant_s && req_wr;

  assign rsp_valid = rsp_r.valid;
  assign rsp_rdata = DATA_W'(rsp_r.rdata);
  assign rsp_err   = rsp_r.err;

  // Storage update: only granted writes reach the data or owner table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        owner_r[i] <= ADMIN_ID;
      end
    end else if (wr_en_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (req_addr == ADDR_W'(i)) begin
          if (req_cfg) begin
            owner_r[i] <= req_wdata[ID_W-1:0];
          end else begin
            data_r[i] <= req_wdata;
          end
        end
      end
    end
  end

  // Read mux for the addressed data register and owner entry.
  always_comb begin
    rd_data_s  = '0;
    rd_owner_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_data_s  = rd_data_s  | (data_r[i]  & {DATA_W{req_addr == ADDR_W'(i)}});
      rd_owner_s = rd_owner_s | (owner_r[i] & {ID_W{req_addr == ADDR_W'(i)}});
    end
  end

  // Next response: read data only on granted reads, error only on denied accepts.
  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = accept_s;
    rsp_d.err   = accept_s && !grant_s;
    if (accept_s && grant_s && !req_wr) begin
      rsp_d.rdata = req_cfg ? RSP_DATA_W'(rd_owner_s) : RSP_DATA_W'(rd_data_s);
    end else begin
      rsp_d.rdata = '0;
    end
  end

  // Response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_r <= '0;
    end else begin
      rsp_r <= rsp_d;
    end
  end

  // Lockout FSM next-state, fail counter and lock timer.
  always_comb begin
    state_d = state_r;
    fail_d  = fail_r;
    timer_d = timer_r;
    case (state_r)
      ST_OPEN: begin
        if (accept_s && !grant_s) begin
          if (fail_r == FAIL_W'(MAX_FAIL - 1)) begin
            state_d = ST_LOCKED;
            fail_d  = '0;
            timer_d = TMR_W'(LOCK_CYCLES - 1);
          end else begin
            fail_d = fail_r + FAIL_W'(1);
          end
        end else if (accept_s) begin
          fail_d = '0;
        end else begin
          fail_d = fail_r;
        end
      end
      ST_LOCKED: begin
        if (timer_r == '0) begin
          state_d = ST_OPEN;
        end else begin
          timer_d = timer_r - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_OPEN;
        fail_d  = '0;
        timer_d = '0;
      end
    endcase
  end

  // Lockout FSM state, fail counter and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_OPEN;
      fail_r  <= '0;
      timer_r <= '0;
    end else begin
      state_r <= state_d;
      fail_r  <= fail_d;
      timer_r <= timer_d;
    end
  end

endmodule

// File: tb/tb_secure_reg_bank.sv
// Scoreboard bench for secure_reg_bank: directed scenarios plus random traffic
// checked against an array-based access-control model.
module tb_secure_reg_bank;

  localparam int         DATA_W      = 8;
  localparam int         ID_W        = 3;
  localparam int         NUM_REGS    = 4;
  localparam int         ADDR_W      = 2;
  localparam int         MAX_FAIL    = 3;
  localparam int         LOCK_CYCLES = 16;
  localparam logic [2:0] ADMIN       = 3'h4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_cfg, req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [ID_W-1:0]   req_id;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_err, locked;
  logic [DATA_W-1:0] rsp_rdata;

  secure_reg_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cfg   (req_cfg),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_id    (req_id),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
    longint            due;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  logic [DATA_W-1:0] m_data[NUM_REGS];
  logic [ID_W-1:0]   m_owner[NUM_REGS];
  int                m_fails;
  int                m_lock_left;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_data[i]  = '0;
      m_owner[i] = ADMIN;
    end
    m_fails     = 0;
    m_lock_left = 0;
  endtask

  // Reference model: owner rule, then effect, then expected response.
  task automatic model_access(input logic c, input logic w, input int a,
                              input logic [ID_W-1:0] id, input logic [DATA_W-1:0] wd);
    exp_t e;
    bit   ok;
    ok = c ? (id == ADMIN) : ((id == m_owner[a]) || (id == ADMIN));
    e.due = cyc + 1;
    if (ok) begin
      m_fails = 0;
      e.err   = 1'b0;
      e.rdata = '0;
      if (w) begin
        if (c) m_owner[a] = wd[ID_W-1:0];
        else   m_data[a]  = wd;
      end else begin
        e.rdata = c ? DATA_W'(m_owner[a]) : m_data[a];
      end
    end else begin
      e.err   = 1'b1;
      e.rdata = '0;
      m_fails++;
      if (m_fails == MAX_FAIL) begin
        m_fails     = 0;
        m_lock_left = LOCK_CYCLES;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic c, input logic w, input int a,
                      input logic [ID_W-1:0] id, input logic [DATA_W-1:0] wd);
    bit exp_locked;
    @(negedge clk);
    exp_locked = (m_lock_left > 0);
    check("locked", 64'(locked), 64'(exp_locked));
    check("req_ready", 64'(req_ready), 64'(!exp_locked));
    req_valid = v;
    req_cfg   = c;
    req_wr    = w;
    req_addr  = ADDR_W'(a);
    req_id    = id;
    req_wdata = wd;
    if (exp_locked) m_lock_left--;
    else if (v) model_access(c, w, a, id, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  // Monitor: every presented response must match the oldest expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata %0h err %0b with no request pending", rsp_rdata, rsp_err);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_latency", 64'(cyc), 64'(e.due));
        end
      end else begin
        check("idle_rsp_zero", 64'({rsp_rdata, rsp_err}), 64'(0));
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_cfg = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_id = '0; req_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_locked", 64'(locked), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));
    rst_n = 1'b1;

    // Admin write/read, owner-gated read, owner transfer.
    step(1'b1, 1'b0, 1'b1, 2, 3'd4, 8'hA5);
    step(1'b1, 1'b0, 1'b0, 2, 3'd4, 8'h00);
    step(1'b1, 1'b0, 1'b0, 2, 3'd1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 2, 3'd4, 8'h01);
    step(1'b1, 1'b0, 1'b0, 2, 3'd1, 8'h00);
    // Non-admin cfg write denied; admin cfg read still sees owner 4.
    step(1'b1, 1'b1, 1'b1, 0, 3'd2, 8'h02);
    step(1'b1, 1'b1, 1'b0, 0, 3'd4, 8'h00);
    // Two denials, a grant, two denials: no lockout.
    step(1'b1, 1'b0, 1'b0, 0, 3'd3, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1, 3'd3, 8'h11);
    step(1'b1, 1'b0, 1'b0, 2, 3'd1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 0, 3'd3, 8'h00);
    step(1'b1, 1'b0, 1'b0, 3, 3'd3, 8'h00);
    idle(2);
    // Three denials from user 3 lock the bank; requests held during lockout.
    step(1'b1, 1'b0, 1'b0, 0, 3'd3, 8'h00);
    step(1'b1, 1'b0, 1'b0, 0, 3'd3, 8'h00);
    step(1'b1, 1'b0, 1'b0, 0, 3'd3, 8'h00);
    for (int i = 0; i < LOCK_CYCLES; i++) step(1'b1, 1'b0, 1'b0, 2, 3'd4, 8'h00);
    step(1'b1, 1'b0, 1'b0, 2, 3'd4, 8'h00);
    idle(2);

    // Random traffic, admin-weighted IDs and occasional cfg accesses.
    for (int n = 0; n < 400; n++) begin
      logic [ID_W-1:0] id;
      id = ($urandom_range(0, 2) == 0) ? ADMIN : ID_W'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, NUM_REGS - 1)), id, DATA_W'($urandom));
    end
    idle(2);

    // Reset in the middle of a lockout.
    step(1'b1, 1'b0, 1'b1, 1, 3'd4, 8'h3C);
    step(1'b1, 1'b1, 1'b0, 1, 3'd5, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1, 3'd5, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1, 3'd5, 8'h00);
    idle(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_locked", 64'(locked), 64'(0));
    check("arst_req_ready", 64'(req_ready), 64'(1));
    check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
    model_reset();
    sb_q.delete();
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < NUM_REGS; a++) begin
      step(1'b1, 1'b0, 1'b0, a, 3'd4, 8'h00);
      step(1'b1, 1'b1, 1'b0, a, 3'd4, 8'h00);
    end
    idle(3);
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
